// File: rtl/irq_claim_ctrl.sv
// Purpose : interrupt claim controller; captures edge/level lines and offers the lowest enabled pending line to the core.
// Latency : irq to irq_valid/irq_offset in 3 cycles (capture, segment search, encode); mask changes reach selection 2 cycles later.
// Backpres: one claim at a time; irq_valid is held low from the ack until 2 cycles after eoi so stale pipeline results drain.
//
// Ports:
//   clk, reset          core clock, synchronous active-high reset
//   irq                 raw interrupt lines (synchronous to clk)
//   irq_mask            1 = line may be selected
//   irq_edge            1 = rising-edge line, 0 = level line
//   irq_valid           an enabled pending line is offered
//   irq_offset          index of the offered line, 0 when none
//   irq_ack             core claims the offered line
//   irq_eoi             core has finished servicing the claimed line
//   irq_busy            a claim is outstanding (CLAIMED or FLUSH)
module irq_claim_ctrl #(
    parameter int  NUM_IRQ  = 32,
    parameter int  SEG_W    = 8,
    localparam int OFFSET_W = $clog2(NUM_IRQ)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_IRQ-1:0]  irq,
    input  logic [NUM_IRQ-1:0]  irq_mask,
    input  logic [NUM_IRQ-1:0]  irq_edge,
    output logic                irq_valid,
    output logic [OFFSET_W-1:0] irq_offset,
    input  logic                irq_ack,
    input  logic                irq_eoi,
    output logic                irq_busy
);

    localparam int NUM_SEG = NUM_IRQ / SEG_W;
    localparam int LIDX_W  = (SEG_W > 1) ? $clog2(SEG_W) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CLAIMED = 2'd1,
        ST_FLUSH   = 2'd2
    } state_t;

    // Capture stage
    logic [NUM_IRQ-1:0]  irq_q;
    logic [NUM_IRQ-1:0]  pending_q;
    logic [NUM_IRQ-1:0]  pending_d;
    logic [NUM_IRQ-1:0]  claim_clr;
    logic [NUM_IRQ-1:0]  eligible;

    // Segment stage
    logic [SEG_W-1:0]    seg_bits_q;
    logic [SEG_W-1:0]    seg_bits_d;
    logic [OFFSET_W-1:0] base_q;
    logic [OFFSET_W-1:0] base_d;
    logic                seg_found_q;
    logic                seg_found_d;

    // Encode stage
    logic [LIDX_W-1:0]   lidx;
    logic [OFFSET_W-1:0] offset_q;
    logic [OFFSET_W-1:0] offset_d;
    logic                found_q;
    logic                found_d;

    // Claim handshake
    state_t              state_q;
    logic [OFFSET_W-1:0] claim_id_q;
    logic [OFFSET_W-1:0] claim_id_d;
    logic                flush_cnt_q;
    logic                claim_accept;

    assign irq_valid    = found_q && (state_q == ST_IDLE);
    assign irq_offset   = offset_q;
    assign irq_busy     = (state_q != ST_IDLE);
    assign claim_accept = irq_valid && irq_ack;

    // The claimed id is taken from the offered offset on the accepting edge,
    // so the edge-line clear below sees the same id that gets latched.
    assign claim_id_d   = claim_accept ? offset_q : claim_id_q;

    // Edge lines accumulate rises until claimed; a rise coinciding with the
    // claim is OR-ed in after the clear so it is not lost.
    always_comb begin
        pending_d = '0;
        claim_clr = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            claim_clr[i] = claim_accept && irq_edge[i] && (claim_id_d == OFFSET_W'(i));
            if (irq_edge[i]) begin
                pending_d[i] = (pending_q[i] & ~claim_clr[i]) | (irq[i] & ~irq_q[i]);
            end else begin
                pending_d[i] = irq[i];
            end
        end
    end

    assign eligible = pending_q & irq_mask;

    // Lowest segment holding an eligible bit; scanning downward lets the
    // lowest index overwrite any higher match.
    always_comb begin
        seg_found_d = 1'b0;
        seg_bits_d  = '0;
        base_d      = '0;
        for (int k = NUM_SEG - 1; k >= 0; k--) begin
            if (|eligible[k*SEG_W +: SEG_W]) begin
                seg_found_d = 1'b1;
                seg_bits_d  = eligible[k*SEG_W +: SEG_W];
                base_d      = OFFSET_W'(k * SEG_W);
            end
        end
    end

    // Lowest set bit within the selected segment.
    always_comb begin
        lidx = '0;
        for (int b = SEG_W - 1; b >= 0; b--) begin
            if (seg_bits_q[b]) begin
                lidx = LIDX_W'(b);
            end
        end
        found_d  = seg_found_q;
        offset_d = seg_found_q ? (base_q + OFFSET_W'(lidx)) : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_q       <= '0;
            pending_q   <= '0;
            seg_bits_q  <= '0;
            base_q      <= '0;
            seg_found_q <= 1'b0;
            offset_q    <= '0;
            found_q     <= 1'b0;
            claim_id_q  <= '0;
            flush_cnt_q <= 1'b0;
            state_q     <= ST_IDLE;
        end else begin
            irq_q       <= irq;
            pending_q   <= pending_d;
            seg_bits_q  <= seg_bits_d;
            base_q      <= base_d;
            seg_found_q <= seg_found_d;
            offset_q    <= offset_d;
            found_q     <= found_d;
            claim_id_q  <= claim_id_d;

            case (state_q)
                ST_IDLE: begin
                    // eoi here, even alongside an ack, has nothing to complete
                    if (claim_accept) begin
                        state_q <= ST_CLAIMED;
                    end
                end
                ST_CLAIMED: begin
                    if (irq_eoi) begin
                        state_q     <= ST_FLUSH;
                        flush_cnt_q <= 1'b0;
                    end
                end
                ST_FLUSH: begin
                    // Two cycles: enough for segment and encode stages to
                    // reflect the post-claim pending vector.
                    if (flush_cnt_q) begin
                        state_q     <= ST_IDLE;
                        flush_cnt_q <= 1'b0;
                    end else begin
                        flush_cnt_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    flush_cnt_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_claim_ctrl.sv
// Purpose : self-checking bench for irq_claim_ctrl (32-line/8-wide and 64-line/16-wide instances).
// Latency : checks the 3-cycle offer latency, 2-cycle mask effect and 2-cycle flush after eoi.
// Backpres: drives ack/eoi handshakes directly; expected offsets flow through a scoreboard queue.
module tb_irq_claim_ctrl;

    localparam int N   = 32;
    localparam int OW  = 5;
    localparam int N2  = 64;
    localparam int OW2 = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset;
    logic [N-1:0]   irq;
    logic [N-1:0]   irq_mask;
    logic [N-1:0]   irq_edge;
    logic           irq_valid;
    logic [OW-1:0]  irq_offset;
    logic           irq_ack;
    logic           irq_eoi;
    logic           irq_busy;

    logic           b_reset;
    logic [N2-1:0]  b_irq;
    logic [N2-1:0]  b_irq_mask;
    logic [N2-1:0]  b_irq_edge;
    logic           b_irq_valid;
    logic [OW2-1:0] b_irq_offset;
    logic           b_irq_ack;
    logic           b_irq_eoi;
    logic           b_irq_busy;

    irq_claim_ctrl #(.NUM_IRQ(N), .SEG_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .irq        (irq),
        .irq_mask   (irq_mask),
        .irq_edge   (irq_edge),
        .irq_valid  (irq_valid),
        .irq_offset (irq_offset),
        .irq_ack    (irq_ack),
        .irq_eoi    (irq_eoi),
        .irq_busy   (irq_busy)
    );

    irq_claim_ctrl #(.NUM_IRQ(N2), .SEG_W(16)) dut_w (
        .clk        (clk),
        .reset      (b_reset),
        .irq        (b_irq),
        .irq_mask   (b_irq_mask),
        .irq_edge   (b_irq_edge),
        .irq_valid  (b_irq_valid),
        .irq_offset (b_irq_offset),
        .irq_ack    (b_irq_ack),
        .irq_eoi    (b_irq_eoi),
        .irq_busy   (b_irq_busy)
    );

    int n_run  = 0;
    int n_fail = 0;
    int exp_q[$];

    // Advance n cycles; inputs are driven and outputs observed 1 time unit after the edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Cycles until irq_valid, -1 if the budget expires.
    task automatic wait_valid(input int budget, output int lat);
        lat = -1;
        for (int c = 1; c <= budget; c++) begin
            step(1);
            if (irq_valid === 1'b1) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic wait_valid_w(input int budget, output int lat);
        lat = -1;
        for (int c = 1; c <= budget; c++) begin
            step(1);
            if (b_irq_valid === 1'b1) begin
                lat = c;
                break;
            end
        end
    endtask

    function automatic int pop_exp();
        if (exp_q.size() == 0) return -1;
        return exp_q.pop_front();
    endfunction

    task automatic test_reset();
        logic [OW-1:0] e;
        reset = 1'b1; irq = '0; irq_mask = '1; irq_edge = '0; irq_ack = 1'b0; irq_eoi = 1'b0;
        b_reset = 1'b1; b_irq = '0; b_irq_mask = '1; b_irq_edge = '0; b_irq_ack = 1'b0; b_irq_eoi = 1'b0;
        irq[4] = 1'b1;
        step(2);
        e = '0;
        n_run++; if (irq_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", irq_valid); end
        n_run++; if (irq_offset !== e) begin n_fail++; $display("FAIL reset_offset: got %0d want 0", irq_offset); end
        n_run++; if (irq_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", irq_busy); end
        n_run++; if (b_irq_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wide_valid: got %b want 0", b_irq_valid); end
        irq = '0;
        reset = 1'b0; b_reset = 1'b0;
        step(4);
    endtask

    task automatic test_level_latency();
        int lat;
        logic [OW-1:0] e;
        irq[13] = 1'b1; exp_q.push_back(13);
        wait_valid(8, lat);
        e = OW'(pop_exp());
        n_run++; if (lat !== 3) begin n_fail++; $display("FAIL level_latency: got %0d cycles want 3", lat); end
        n_run++; if (irq_offset !== e) begin n_fail++; $display("FAIL level_offset: got %0d want %0d", irq_offset, e); end
        n_run++; if (irq_busy !== 1'b0) begin n_fail++; $display("FAIL level_busy: got %b want 0", irq_busy); end
        irq[13] = 1'b0;
        step(4);
        n_run++; if (irq_valid !== 1'b0) begin n_fail++; $display("FAIL level_drop: got %b want 0", irq_valid); end
    endtask

    task automatic test_priority_mask();
        int lat;
        logic [OW-1:0] e;
        irq[5] = 1'b1; irq[20] = 1'b1; exp_q.push_back(5);
        wait_valid(8, lat);
        e = OW'(pop_exp());
        n_run++; if (lat !== 3) begin n_fail++; $display("FAIL prio_latency: got %0d cycles want 3", lat); end
        n_run++; if (irq_offset !== e) begin n_fail++; $display("FAIL prio_offset: got %0d want %0d", irq_offset, e); end
        irq_mask[5] = 1'b0; exp_q.push_back(20);
        step(2);
        e = OW'(pop_exp());
        n_run++; if (irq_valid !== 1'b1) begin n_fail++; $display("FAIL mask_valid: got %b want 1", irq_valid); end
        n_run++; if (irq_offset !== e) begin n_fail++; $display("FAIL mask_offset: got %0d want %0d", irq_offset, e); end
        irq = '0; irq_mask = '1;
        step(4);
    endtask

    task automatic test_edge_claim();
        int lat;
        int seen;
        logic [OW-1:0] e;
        irq_edge[9] = 1'b1;
        irq[9] = 1'b1; exp_q.push_back(9);
        step(1);
        irq[9] = 1'b0;
        wait_valid(8, lat);
        e = OW'(pop_exp());
        n_run++; if (lat + 1 !== 3) begin n_fail++; $display("FAIL edge_latency: got %0d cycles want 3", lat + 1); end
        n_run++; if (irq_offset !== e) begin n_fail++; $display("FAIL edge_offset: got %0d want %0d", irq_offset, e); end
        irq_ack = 1'b1; step(1); irq_ack = 1'b0;
        n_run++; if (irq_busy !== 1'b1) begin n_fail++; $display("FAIL claim_busy: got %b want 1", irq_busy); end
        n_run++; if (irq_valid !== 1'b0) begin n_fail++; $display("FAIL claim_valid: got %b want 0", irq_valid); end
        irq_eoi = 1'b1; step(1); irq_eoi = 1'b0;
        n_run++; if (irq_busy !== 1'b1) begin n_fail++; $display("FAIL flush0_busy: got %b want 1", irq_busy); end
        step(1);
        n_run++; if (irq_busy !== 1'b1) begin n_fail++; $display("FAIL flush1_busy: got %b want 1", irq_busy); end
        n_run++; if (irq_valid !== 1'b0) begin n_fail++; $display("FAIL flush1_valid: got %b want 0", irq_valid); end
        step(1);
        n_run++; if (irq_busy !== 1'b0) begin n_fail++; $display("FAIL flush_end_busy: got %b want 0", irq_busy); end
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            if (irq_valid === 1'b1) seen++;
            step(1);
        end
        n_run++; if (seen !== 0) begin n_fail++; $display("FAIL edge_cleared: valid seen %0d cycles want 0", seen); end
    endtask

    task automatic test_edge_rerise();
        int lat;
        logic [OW-1:0] e;
        irq[9] = 1'b1; exp_q.push_back(9);
        step(1);
        irq[9] = 1'b0;
        wait_valid(8, lat);
        e = OW'(pop_exp());
        n_run++; if (irq_offset !== e) begin n_fail++; $display("FAIL rerise_first_offset: got %0d want %0d", irq_offset, e); end
        exp_q.push_back(9);
        irq_ack = 1'b1; irq[9] = 1'b1;
        step(1);
        irq_ack = 1'b0; irq[9] = 1'b0;
        irq_eoi = 1'b1; step(1); irq_eoi = 1'b0;
        n_run++; if (irq_valid !== 1'b0) begin n_fail++; $display("FAIL rerise_flush0_valid: got %b want 0", irq_valid); end
        step(1);
        n_run++; if (irq_valid !== 1'b0) begin n_fail++; $display("FAIL rerise_flush1_valid: got %b want 0", irq_valid); end
        step(1);
        e = OW'(pop_exp());
        n_run++; if (irq_valid !== 1'b1) begin n_fail++; $display("FAIL rerise_valid: got %b want 1", irq_valid); end
        n_run++; if (irq_offset !== e) begin n_fail++; $display("FAIL rerise_offset: got %0d want %0d", irq_offset, e); end
        irq_ack = 1'b1; step(1); irq_ack = 1'b0;
        irq_eoi = 1'b1; step(1); irq_eoi = 1'b0;
        step(4);
        n_run++; if (irq_busy !== 1'b0 || irq_valid !== 1'b0) begin
            n_fail++; $display("FAIL rerise_cleanup: busy %b valid %b want 0 0", irq_busy, irq_valid);
        end
        irq_edge = '0;
    endtask

    task automatic test_masked_edge();
        int seen;
        logic [OW-1:0] e;
        irq_edge[30] = 1'b1; irq_mask[30] = 1'b0;
        irq[30] = 1'b1; step(1); irq[30] = 1'b0;
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            step(1);
            if (irq_valid === 1'b1) seen++;
        end
        n_run++; if (seen !== 0) begin n_fail++; $display("FAIL masked_no_valid: valid seen %0d cycles want 0", seen); end
        irq_ack = 1'b1; step(1); irq_ack = 1'b0;
        n_run++; if (irq_busy !== 1'b0) begin n_fail++; $display("FAIL stray_ack_busy: got %b want 0", irq_busy); end
        irq_eoi = 1'b1; step(1); irq_eoi = 1'b0;
        n_run++; if (irq_busy !== 1'b0) begin n_fail++; $display("FAIL stray_eoi_busy: got %b want 0", irq_busy); end
        irq_mask[30] = 1'b1; exp_q.push_back(30);
        step(1);
        n_run++; if (irq_valid !== 1'b0) begin n_fail++; $display("FAIL unmask_early_valid: got %b want 0", irq_valid); end
        step(1);
        e = OW'(pop_exp());
        n_run++; if (irq_valid !== 1'b1) begin n_fail++; $display("FAIL unmask_valid: got %b want 1", irq_valid); end
        n_run++; if (irq_offset !== e) begin n_fail++; $display("FAIL unmask_offset: got %0d want %0d", irq_offset, e); end
        // eoi alongside the ack must not complete the claim
        irq_ack = 1'b1; irq_eoi = 1'b1; step(1); irq_ack = 1'b0; irq_eoi = 1'b0;
        step(3);
        n_run++; if (irq_busy !== 1'b1) begin n_fail++; $display("FAIL ack_eoi_same_cycle_busy: got %b want 1", irq_busy); end
        irq_eoi = 1'b1; step(1); irq_eoi = 1'b0;
        step(2);
        n_run++; if (irq_busy !== 1'b0 || irq_valid !== 1'b0) begin
            n_fail++; $display("FAIL masked_cleanup: busy %b valid %b want 0 0", irq_busy, irq_valid);
        end
        irq_edge = '0;
        step(2);
    endtask

    task automatic test_back_to_back();
        int lat;
        logic [OW-1:0] e;
        irq[3] = 1'b1; irq[7] = 1'b1; exp_q.push_back(3); exp_q.push_back(7);
        wait_valid(8, lat);
        e = OW'(pop_exp());
        n_run++; if (irq_offset !== e) begin n_fail++; $display("FAIL b2b_first_offset: got %0d want %0d", irq_offset, e); end
        irq_ack = 1'b1; step(1); irq_ack = 1'b0; irq[3] = 1'b0;
        irq_eoi = 1'b1; step(1); irq_eoi = 1'b0;
        wait_valid(8, lat);
        e = OW'(pop_exp());
        n_run++; if (lat !== 2) begin n_fail++; $display("FAIL b2b_reoffer_latency: got %0d cycles after eoi want 2", lat); end
        n_run++; if (irq_offset !== e) begin n_fail++; $display("FAIL b2b_second_offset: got %0d want %0d", irq_offset, e); end
        irq[7] = 1'b0;
        irq_ack = 1'b1; step(1); irq_ack = 1'b0;
        irq_eoi = 1'b1; step(1); irq_eoi = 1'b0;
        step(4);
    endtask

    task automatic test_reset_mid_claim();
        int lat;
        int seen;
        logic [OW-1:0] e;
        irq[13] = 1'b1; exp_q.push_back(13);
        wait_valid(8, lat);
        e = OW'(pop_exp());
        n_run++; if (irq_offset !== e) begin n_fail++; $display("FAIL midrst_offset: got %0d want %0d", irq_offset, e); end
        irq_ack = 1'b1; step(1); irq_ack = 1'b0; irq[13] = 1'b0;
        n_run++; if (irq_busy !== 1'b1) begin n_fail++; $display("FAIL midrst_claim_busy: got %b want 1", irq_busy); end
        irq_edge[30] = 1'b1; irq_mask[30] = 1'b0;
        irq[30] = 1'b1; step(1); irq[30] = 1'b0; step(1);
        reset = 1'b1; step(1); reset = 1'b0;
        e = '0;
        n_run++; if (irq_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", irq_busy); end
        n_run++; if (irq_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b want 0", irq_valid); end
        n_run++; if (irq_offset !== e) begin n_fail++; $display("FAIL midrst_offset_zero: got %0d want 0", irq_offset); end
        irq_mask = '1;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            step(1);
            if (irq_valid === 1'b1) seen++;
        end
        n_run++; if (seen !== 0) begin n_fail++; $display("FAIL midrst_pending_lost: valid seen %0d cycles want 0", seen); end
        irq_edge = '0;
    endtask

    task automatic test_wide();
        int lat;
        logic [OW2-1:0] e;
        b_irq[47] = 1'b1; exp_q.push_back(47);
        wait_valid_w(8, lat);
        e = OW2'(pop_exp());
        n_run++; if (lat !== 3) begin n_fail++; $display("FAIL wide_latency: got %0d cycles want 3", lat); end
        n_run++; if (b_irq_offset !== e) begin n_fail++; $display("FAIL wide_offset47: got %0d want %0d", b_irq_offset, e); end
        b_irq = '0;
        step(4);
        n_run++; if (b_irq_valid !== 1'b0) begin n_fail++; $display("FAIL wide_drop: got %b want 0", b_irq_valid); end
        b_irq[63] = 1'b1; b_irq[17] = 1'b1; exp_q.push_back(17);
        wait_valid_w(8, lat);
        e = OW2'(pop_exp());
        n_run++; if (b_irq_offset !== e) begin n_fail++; $display("FAIL wide_offset17: got %0d want %0d", b_irq_offset, e); end
        b_irq = '0;
        step(4);
    endtask

    initial begin
        test_reset();
        test_level_latency();
        test_priority_mask();
        test_edge_claim();
        test_edge_rerise();
        test_masked_edge();
        test_back_to_back();
        test_reset_mid_claim();
        test_wide();
        n_run++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL scoreboard_drain: %0d entries left want 0", exp_q.size()); end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/irq_claim_ctrl.md
# irq_claim_ctrl

Parametrised interrupt claim controller for NanoCore. It captures NUM_IRQ interrupt lines, with edge or level mode selectable per line, and resolves the lowest-numbered enabled pending line through a pipelined segment/priority search. It presents that line as irq_offset/irq_valid to the core and runs a claim (ack) / complete (eoi) handshake with the core's trap logic. It sits between the SoC interrupt sources and the core's trap entry, which uses irq_offset to index the vector table.

## Interface
- NUM_IRQ, 32, number of interrupt lines; must be a multiple of SEG_W, range 8..256
- SEG_W, 8, segment width used by the first search stage; must be a power of two
- OFFSET_W (localparam), $clog2(NUM_IRQ), width of irq_offset
- clk  input  1  core clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- irq  input  NUM_IRQ  raw interrupt lines, synchronous to clk
- irq_mask  input  NUM_IRQ  1 = line enabled for selection
- irq_edge  input  NUM_IRQ  1 = line is rising-edge triggered, 0 = level
- irq_valid  output  1  an enabled pending line is offered to the core
- irq_offset  output  OFFSET_W  index of the offered line; 0 when none
- irq_ack  input  1  core claims the offered line (meaningful only with irq_valid)
- irq_eoi  input  1  core finished servicing the claimed line
- irq_busy  output  1  a claim is outstanding (state CLAIMED or FLUSH)

## Operation
- Capture stage, registers irq_q and pending:
  - irq_q <= irq every cycle.
  - Level line: pending[i] <= irq[i].
  - Edge line: pending[i] <= pending[i] | (irq[i] & ~irq_q[i]), cleared by a claim of line i.
  - A simultaneous new rise on the claimed line wins over the clear; the bit stays set.
  - Edges are captured regardless of irq_mask. A masked pending bit is delivered once its mask bit is set.
- Segment stage:
  - eligible = pending & irq_mask.
  - Pick the lowest segment k (NUM_IRQ/SEG_W segments) with any eligible bit.
  - Register seg_bits = eligible[k*SEG_W +: SEG_W], base = k*SEG_W, and seg_found.
- Encode stage:
  - Register irq_offset = base + index of the lowest set bit of seg_bits, and found = seg_found.
  - If no bit is set, irq_offset <= 0 and found <= 0.
- irq_valid = found && state == IDLE.
- State machine, states IDLE, CLAIMED, FLUSH:
  - IDLE: irq_valid && irq_ack → CLAIMED. Latch claim_id <= irq_offset. If irq_edge[claim_id], clear pending[claim_id] on the same edge. irq_ack without irq_valid is ignored.
  - CLAIMED: irq_valid forced 0; the pipeline keeps running. irq_eoi → FLUSH. irq_ack is ignored.
  - FLUSH: a 2-cycle counter, then → IDLE. This drains stale pipeline results. irq_eoi and irq_ack are ignored.
  - irq_eoi in IDLE is ignored. irq_eoi sampled in the same cycle as the ack in IDLE is ignored.
- Level lines are not cleared by a claim. The source must deassert before irq_eoi, otherwise the same line is re-offered after FLUSH.
- Non-nested: at most one outstanding claim.

## Timing
- Reset, sampled at a rising edge, sets:
  - irq_q, pending, seg_bits, base, seg_found, found, claim_id and the flush counter to 0
  - state to IDLE, irq_offset to 0, irq_valid to 0, irq_busy to 0
- Latency: irq asserted in cycle 0 → pending set after edge 1 → segment after edge 2 → irq_valid/irq_offset high in cycle 3.
- irq_mask/irq_edge changes take effect on selection 2 cycles later. Mid-pipeline changes may deliver at most one result computed under the old mask.
- Ack accepted at edge A: irq_busy = 1 from cycle A. irq_valid is 0 from A until FLUSH ends.
- eoi accepted at edge E: FLUSH for cycles E and E+1, IDLE after edge E+2. The earliest new irq_valid is cycle E+2.
- Priority is fixed: lowest index wins, both across and within segments.
- Reset mid-claim: all state returns to IDLE and pending is lost. Edges occurring during reset are not captured.
- Width rules: base + local index never exceeds NUM_IRQ-1. irq_offset has no overflow, by the parameter constraints.

## Test plan
- NUM_IRQ=32, all level, mask all ones; assert irq[13] in cycle 0 → irq_valid=1 and irq_offset=13 in cycle 3; irq_busy=0.
- Assert irq[5] and irq[20] together → irq_offset=5. Mask bit 5 → after 2 cycles irq_offset=20.
- Edge line 9: 1-cycle pulse, then ack at first irq_valid → pending[9] cleared, irq_busy=1, irq_valid=0. eoi → irq_valid stays 0 through FLUSH and after.
- Edge line 9: new rise in the same cycle as its ack → after eoi+2 cycles, irq_valid=1 and irq_offset=9 again.
- Edge line 30 pulsed while masked → no irq_valid. Unmask → irq_valid=1 and irq_offset=30 two cycles later. Also, irq_ack while irq_valid=0 and irq_eoi in IDLE → no state change.
- Reset asserted while CLAIMED → next cycle irq_busy=0, irq_valid=0, irq_offset=0, pending=0. NUM_IRQ=64, SEG_W=16 with irq[47] → irq_offset=47.
